// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the CPU HI/LO registers.
// One result bit per cycle; signed ops run on magnitudes with a final sign-fix cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       oper,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_count;
    logic             r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_bzero;
    logic [WIDTH-1:0] r_a_orig;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_upper;
    logic [WIDTH-1:0] r_lower;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_signed;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [PW-1:0]    w_prod;
    logic [PW-1:0]    w_prod_fix;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (r_count == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand magnitudes, one iteration step, and final sign correction
    always_comb begin
        w_signed   = ~oper[0];
        w_a_mag    = (w_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        w_b_mag    = (w_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        w_mul_sum  = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_op_b} : (WIDTH + 1)'(0));
        w_shift    = {r_upper, r_lower[WIDTH-1]};
        w_diff     = w_shift - {1'b0, r_op_b};
        w_ge       = ~w_diff[WIDTH];
        w_prod     = {r_upper, r_lower};
        w_prod_fix = r_neg_q ? (~w_prod + PW'(1)) : w_prod;
        w_q_fix    = r_neg_q ? (~r_lower + WIDTH'(1)) : r_lower;
        w_r_fix    = r_neg_r ? (~r_upper + WIDTH'(1)) : r_upper;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_a_orig <= '0;
            r_op_b   <= '0;
            r_upper  <= '0;
            r_lower  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_div    <= oper[1];
                        r_neg_q  <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r  <= w_signed & a[WIDTH-1];
                        r_bzero  <= oper[1] & (b == '0);
                        r_a_orig <= a;
                        r_op_b   <= w_b_mag;
                        r_upper  <= '0;
                        r_lower  <= w_a_mag;
                        r_count  <= '0;
                    end
                end
                S_CALC: begin
                    r_count <= r_count + CW'(1);
                    if (r_div) begin
                        // Restoring step: remainder < divisor, so the unrestored shift fits WIDTH bits
                        r_upper <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_lower <= {r_lower[WIDTH-2:0], w_ge};
                    end else begin
                        r_upper <= w_mul_sum[WIDTH:1];
                        r_lower <= {w_mul_sum[0], r_lower[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (!r_div) begin
                        r_hi <= w_prod_fix[PW-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else if (r_bzero) begin
                        r_hi <= r_a_orig;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + scoreboard bench for muldiv_unit: results queued at start, checked on done.
module tb_muldiv_unit;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  oper;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .oper(oper), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model returning {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (op)
            2'b00: return sx * sy;
            2'b01: return {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                            input logic push, input logic [63:0] expv);
        start = 1'b1;
        oper  = op;
        a     = x;
        b     = y;
        if (push) sb.push_back(expv);
    endtask

    // Wait for done; optionally inject a start+MTHI while busy at cycle inj_at
    task automatic wait_done(input int inj_at);
        int   lat;
        exp_t e;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == inj_at) begin
                start = 1'b1; oper = 2'b00; a = 32'd2; b = 32'd3;
                hi_we = 1'b1; wdata = 32'hDEAD;
            end else if (lat == inj_at + 1) begin
                start = 1'b0; hi_we = 1'b0;
            end
        end
        check("done_seen", 64'(done), 64'd1);
        check("latency", 64'(lat), 64'd33);
        check("busy_in_done", 64'(busy), 64'd0);
        check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("hi", 64'(hi), 64'(e.hi));
            check("lo", 64'(lo), 64'(e.lo));
        end
    endtask

    initial begin
        int          ndone;
        logic [1:0]  rop;
        logic [31:0] rx;
        logic [31:0] ry;
        rst = 1'b1; start = 1'b0; oper = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);

        // MTLO, then MTHI+MTLO together
        lo_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h1234);
        check("mtlo_hi", 64'(hi), 64'd0);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55AA;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mtboth_hi", 64'(hi), 64'h55AA);
        check("mtboth_lo", 64'(lo), 64'h55AA);

        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {32'hFFFF_FFFE, 32'h0000_0001});
        wait_done(-1);
        @(negedge clk);
        start_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        wait_done(-1);
        @(negedge clk);
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_done(-1);
        @(negedge clk);
        start_op(2'b11, 32'd100, 32'd0, 1'b1, {32'h0000_0064, 32'hFFFF_FFFF});
        wait_done(-1);
        @(negedge clk);
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000});
        wait_done(-1);
        @(negedge clk);
        start_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b1, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        wait_done(-1);
        @(negedge clk);
        start_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1, model(2'b10, 32'd7, 32'hFFFF_FFFE));
        wait_done(-1);
        @(negedge clk);

        // start and MTHI while busy are both ignored
        start_op(2'b11, 32'd1000, 32'd7, 1'b1, {32'd6, 32'd142});
        wait_done(5);
        @(negedge clk);

        // MTHI on the accepting edge is overwritten by the result
        hi_we = 1'b1; wdata = 32'hBEEF;
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'd1});
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_at_start", 64'(hi), 64'hBEEF);
        start = 1'b0;
        ndone = 0;
        while (!done && ndone < 100) begin
            @(negedge clk);
            ndone++;
        end
        check("mthi_at_start_done_lat", 64'(ndone), 64'd33);
        void'(sb.pop_front());
        check("mthi_overwritten_hi", 64'(hi), 64'd0);
        check("mthi_overwritten_lo", 64'(lo), 64'd1);
        @(negedge clk);

        // Reset mid-operation aborts without a done pulse
        start_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'd0);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        start_op(2'b01, 32'd12345, 32'd678, 1'b1, model(2'b01, 32'd12345, 32'd678));
        wait_done(-1);

        // Back-to-back: start raised in the done cycle
        start_op(2'b10, 32'hFFFF_FC18, 32'd7, 1'b1, model(2'b10, 32'hFFFF_FC18, 32'd7));
        wait_done(-1);
        start_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, model(2'b00, 32'h7FFF_FFFF, 32'h8000_0000));
        wait_done(-1);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            rx  = $urandom;
            ry  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 50));
            if (i % 2 == 1 && rop[1] == 1'b0) ry = ~ry;
            start_op(rop, rx, ry, 1'b1, model(rop, rx, ry));
            wait_done(-1);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
